view_mode_ctrl: RTL and testbench

//  Sequences the display-mode configuration of the camera datapath (grid overlay on/off, full/half-size image).

---
 rtl/view_mode_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_view_mode_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/view_mode_ctrl.sv
// Purpose  : display-mode sequencer for the camera datapath (grid overlay, full/half geometry);
//            debounces a user button, queues mode changes and applies them only at frame boundaries.
// Latency  : press event 3 + DEBOUNCE_CYC cycles after a clean button edge; the mode applies on the frame-end pixel edge.
// Backpress: none; the camera write stream is observed only, and presses are accumulated into one queued target.
//
// Optional feature: define MODE_TIMEOUT_EN to force a queued change through after TIMEOUT_CYC cycles
// without a frame end (stalled or absent camera).
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   i_btn                raw user button (asynchronous, active-high)
//   i_we/i_line/i_pixel  camera write stream, shared with the overlay stage
//   o_overlay_en         grid overlay enable (mode bit 0)
//   o_imag_resized       half-size geometry select (mode bit 1)
//   o_imag_depth/width   active frame geometry
//   o_mode               active mode: 0 RAW_FULL, 1 GRID_FULL, 2 RAW_HALF, 3 GRID_HALF
//   o_pending            a mode change is queued
//   o_frame_end          1-cycle pulse after the last pixel of a frame
module view_mode_ctrl #(
  parameter int CAM_LINE     = 9,
  parameter int CAM_PIXEL    = 10,
  parameter int FULL_DEPTH   = 480,
  parameter int FULL_WIDTH   = 640,
  parameter int HALF_DEPTH   = 240,
  parameter int HALF_WIDTH   = 320,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int TIMEOUT_CYC  = 4000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_btn,
  input  logic                 i_we,
  input  logic [CAM_LINE-1:0]  i_line,
  input  logic [CAM_PIXEL-1:0] i_pixel,
  output logic                 o_overlay_en,
  output logic                 o_imag_resized,
  output logic [CAM_LINE-1:0]  o_imag_depth,
  output logic [CAM_PIXEL-1:0] o_imag_width,
  output logic [1:0]           o_mode,
  output logic                 o_pending,
  output logic                 o_frame_end
);

  localparam logic [CAM_LINE-1:0]  DEPTH_FULL = CAM_LINE'(FULL_DEPTH);
  localparam logic [CAM_LINE-1:0]  DEPTH_HALF = CAM_LINE'(HALF_DEPTH);
  localparam logic [CAM_PIXEL-1:0] WIDTH_FULL = CAM_PIXEL'(FULL_WIDTH);
  localparam logic [CAM_PIXEL-1:0] WIDTH_HALF = CAM_PIXEL'(HALF_WIDTH);

  localparam int              DB_W    = $clog2(DEBOUNCE_CYC);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t state;
  logic [1:0] target;

  // ---------------------------------------------------------------------------
  // Button path: 2-FF synchronizer, then a stability counter on the synced level.
  // btn_prev is the synced level one cycle earlier; any difference restarts the count.
  // ---------------------------------------------------------------------------
  logic            btn_s1;
  logic            btn_s2;
  logic            btn_prev;
  logic            db_level;
  logic [DB_W-1:0] db_cnt;
  logic            db_stable;
  logic            db_done;
  logic            press;

  assign db_stable = (btn_s2 == btn_prev);
  assign db_done   = db_stable && (db_cnt == DB_LAST);
  // Only the 0->1 transition of the accepted level is an event; release is silent.
  assign press     = db_done && btn_s2 && !db_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1   <= 1'b0;
      btn_s2   <= 1'b0;
      btn_prev <= 1'b0;
      db_level <= 1'b0;
      db_cnt   <= '0;
    end else begin
      btn_s1   <= i_btn;
      btn_s2   <= btn_s1;
      btn_prev <= btn_s2;
      if (!db_stable) begin
        db_cnt <= '0;
      end else if (db_cnt != DB_LAST) begin
        db_cnt <= db_cnt + DB_W'(1);
      end else begin
        // Counter saturates here so the level keeps tracking until the next change.
        db_level <= btn_s2;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame end is decoded against the geometry currently driven, so a frame in
  // half-size mode ends at the half-size corner pixel.
  // ---------------------------------------------------------------------------
  logic frame_hit;

  assign frame_hit = i_we &&
                     (i_line  == o_imag_depth - CAM_LINE'(1)) &&
                     (i_pixel == o_imag_width - CAM_PIXEL'(1));

  // ---------------------------------------------------------------------------
  // Forced apply when the camera stops delivering frames.
  // ---------------------------------------------------------------------------
  logic timeout;

`ifdef MODE_TIMEOUT_EN
  localparam int              TO_W    = $clog2(TIMEOUT_CYC);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] to_cnt;

  assign timeout = (state == PENDING) && (to_cnt == TO_LAST);

  // Held at zero outside PENDING so every queued change gets the full window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if ((state != PENDING) || frame_hit || timeout) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end
`else
  // Without the timeout a queued change waits for a real frame end; the
  // timeout length has no effect in this build.
  logic [31:0] cfg_unused;

  assign timeout    = 1'b0;
  assign cfg_unused = 32'(TIMEOUT_CYC);
`endif

  // ---------------------------------------------------------------------------
  // Mode FSM with registered outputs. Geometry/overlay outputs are written in
  // the same step as o_mode so they can never disagree.
  // ---------------------------------------------------------------------------
  logic apply;

  assign apply = frame_hit || timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      target         <= 2'd0;
      o_mode         <= 2'd0;
      o_overlay_en   <= 1'b0;
      o_imag_resized <= 1'b0;
      o_imag_depth   <= DEPTH_FULL;
      o_imag_width   <= WIDTH_FULL;
      o_pending      <= 1'b0;
      o_frame_end    <= 1'b0;
    end else begin
      o_frame_end <= frame_hit;
      case (state)
        IDLE: begin
          // A frame end in IDLE has nothing to apply.
          if (press) begin
            target    <= o_mode + 2'd1;
            state     <= PENDING;
            o_pending <= 1'b1;
          end
        end
        PENDING: begin
          if (apply) begin
            o_mode         <= target;
            o_overlay_en   <= target[0];
            o_imag_resized <= target[1];
            o_imag_depth   <= target[1] ? DEPTH_HALF : DEPTH_FULL;
            o_imag_width   <= target[1] ? WIDTH_HALF : WIDTH_FULL;
            if (press) begin
              // Same-cycle press queues one step past the mode just applied.
              target <= target + 2'd1;
            end else begin
              state     <= IDLE;
              o_pending <= 1'b0;
            end
          end else if (press) begin
            target <= target + 2'd1;
          end
        end
        default: begin
          state     <= IDLE;
          o_pending <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_view_mode_ctrl.sv
// Directed bench for view_mode_ctrl with a short debounce (4) and timeout (64).
module tb_view_mode_ctrl;

  logic       clk;
  logic       rst_n;
  logic       btn;
  logic       we;
  logic [8:0] line;
  logic [9:0] pixel;
  logic       overlay_en;
  logic       imag_resized;
  logic [8:0] imag_depth;
  logic [9:0] imag_width;
  logic [1:0] mode;
  logic       pending;
  logic       frame_end;

  int tests;
  int fails;

  view_mode_ctrl #(
    .CAM_LINE    (9),
    .CAM_PIXEL   (10),
    .FULL_DEPTH  (480),
    .FULL_WIDTH  (640),
    .HALF_DEPTH  (240),
    .HALF_WIDTH  (320),
    .DEBOUNCE_CYC(4),
    .TIMEOUT_CYC (64)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_btn         (btn),
    .i_we          (we),
    .i_line        (line),
    .i_pixel       (pixel),
    .o_overlay_en  (overlay_en),
    .o_imag_resized(imag_resized),
    .o_imag_depth  (imag_depth),
    .o_imag_width  (imag_width),
    .o_mode        (mode),
    .o_pending     (pending),
    .o_frame_end   (frame_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clean press followed by a clean release.
  task automatic do_press();
    btn = 1'b1;
    tick(10);
    btn = 1'b0;
    tick(10);
  endtask

  // Single camera write on one clock edge.
  task automatic cam_px(input int l, input int p);
    we    = 1'b1;
    line  = 9'(l);
    pixel = 10'(p);
    tick(1);
    we    = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    btn   = 1'b0;
    we    = 1'b0;
    line  = '0;
    pixel = '0;

    // T1 reset values, and held after release
    tick(3);
    chk("rst_mode", 32'(mode), 0);
    chk("rst_overlay", 32'(overlay_en), 0);
    chk("rst_resized", 32'(imag_resized), 0);
    chk("rst_depth", 32'(imag_depth), 480);
    chk("rst_width", 32'(imag_width), 640);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_frame_end", 32'(frame_end), 0);
    rst_n = 1'b1;
    tick(3);
    chk("post_rst_mode", 32'(mode), 0);
    chk("post_rst_depth", 32'(imag_depth), 480);
    chk("post_rst_pending", 32'(pending), 0);

    // T2 short glitches are rejected, a stable level is accepted
    for (int g = 0; g < 3; g++) begin
      btn = 1'b1;
      tick(3);
      btn = 1'b0;
      tick(3);
    end
    tick(10);
    chk("glitch_pending", 32'(pending), 0);
    chk("glitch_mode", 32'(mode), 0);
    btn = 1'b1;
    tick(10);
    chk("press_pending", 32'(pending), 1);
    chk("press_mode", 32'(mode), 0);
    btn = 1'b0;
    tick(10);
    chk("release_pending", 32'(pending), 1);

    // T3 apply at frame end; frame-end pixel with we=0 ignored
    we = 1'b0; line = 9'd479; pixel = 10'd639;
    tick(1);
    chk("we0_mode", 32'(mode), 0);
    chk("we0_frame_end", 32'(frame_end), 0);
    cam_px(479, 639);
    chk("apply1_mode", 32'(mode), 1);
    chk("apply1_overlay", 32'(overlay_en), 1);
    chk("apply1_frame_end", 32'(frame_end), 1);
    chk("apply1_pending", 32'(pending), 0);
    chk("apply1_depth", 32'(imag_depth), 480);
    tick(1);
    chk("frame_end_pulse", 32'(frame_end), 0);

    // T4 three presses from mode 1 wrap the target to 0
    do_press();
    do_press();
    do_press();
    chk("multi_mode_hold", 32'(mode), 1);
    cam_px(479, 639);
    chk("wrap_mode", 32'(mode), 0);
    chk("wrap_overlay", 32'(overlay_en), 0);
    chk("wrap_pending", 32'(pending), 0);

    // reach mode 2 (half geometry)
    do_press();
    do_press();
    cam_px(479, 639);
    chk("half_mode", 32'(mode), 2);
    chk("half_resized", 32'(imag_resized), 1);
    chk("half_depth", 32'(imag_depth), 240);
    chk("half_width", 32'(imag_width), 320);

    // full-size corner is not a frame end in half geometry
    do_press();
    cam_px(479, 639);
    chk("full_px_in_half_mode", 32'(mode), 2);
    chk("full_px_in_half_pending", 32'(pending), 1);
    chk("full_px_in_half_fe", 32'(frame_end), 0);
    cam_px(239, 319);
    chk("half_px_mode", 32'(mode), 3);
    chk("half_px_overlay", 32'(overlay_en), 1);
    chk("half_px_pending", 32'(pending), 0);
    chk("half_px_fe", 32'(frame_end), 1);

    // T5 collision: target 2 queued, press and frame end on the same edge
    do_press();
    do_press();
    do_press();
    chk("coll_pre_mode", 32'(mode), 3);
    btn = 1'b1;
    tick(6);
    chk("coll_pre_pending", 32'(pending), 1);
    cam_px(239, 319);
    chk("coll_mode", 32'(mode), 2);
    chk("coll_pending", 32'(pending), 1);
    chk("coll_fe", 32'(frame_end), 1);
    chk("coll_overlay", 32'(overlay_en), 0);
    btn = 1'b0;
    tick(10);
    cam_px(239, 319);
    chk("coll_target3_mode", 32'(mode), 3);
    chk("coll_target3_pending", 32'(pending), 0);

    // T6 no camera writes while pending
`ifdef MODE_TIMEOUT_EN
    btn = 1'b1;
    tick(7);
    chk("to_entry_pending", 32'(pending), 1);
    tick(63);
    chk("to_before_mode", 32'(mode), 3);
    chk("to_before_pending", 32'(pending), 1);
    tick(1);
    chk("to_mode", 32'(mode), 0);
    chk("to_pending", 32'(pending), 0);
    chk("to_fe", 32'(frame_end), 0);
    btn = 1'b0;
    tick(10);
`else
    do_press();
    tick(1000);
    chk("hold_pending", 32'(pending), 1);
    chk("hold_mode", 32'(mode), 3);
`endif

    // mid-pending reset discards the queued change
    do_press();
    chk("pre_rst_pending", 32'(pending), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_mode", 32'(mode), 0);
    chk("async_rst_pending", 32'(pending), 0);
    chk("async_rst_depth", 32'(imag_depth), 480);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    cam_px(479, 639);
    chk("discard_mode", 32'(mode), 0);
    chk("discard_pending", 32'(pending), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
